// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data-memory responder for the MEM stage of the RV32I pipeline.
//   It raises memory_busy for LATENCY cycles per access so the stall controller
//   freezes PC and IF/ID. On the edge that enters DONE it either returns
//   sign/zero-extended load data or commits byte-enabled store data. The
//   pipeline then advances during the DONE cycle.
//
// Parameters
//   LATENCY      cycles memory_busy is held per access (>= 1)
//   DEPTH_WORDS  word count of the internal array (power of 2, >= 2)
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   mem_read         load request (held stable while busy)
//   mem_write        store request (held stable while busy), wins over mem_read
//   funct3           000 B, 001 H, 010 W, 100 BU, 101 HU, others treated as W
//   addr             byte address (upper bits beyond the array wrap)
//   write_data       LSB-aligned store data
//   read_data        registered, extended load data
//   memory_busy      stall request to the stall controller
//   misaligned_fault misaligned-access flag to the trap logic
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned H/W requests are rejected
//                          in IDLE with misaligned_fault=1; when undefined the
//                          address is forced to natural alignment instead.
module dmem_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        memory_busy,
  output logic        misaligned_fault
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int AW = $clog2(DEPTH_WORDS);
  // ACCESS cycles still needed after the IDLE request cycle.
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          req;
  logic          fault_now;
  logic          enter_done;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic [31:0]   word;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [31:0]   load_value;
  logic [3:0]    byte_en;
  logic [31:0]   store_data;
  logic          unused_addr_bits;

  logic [31:0] mem [DEPTH_WORDS];

  assign req              = mem_read | mem_write;
  assign word_idx         = addr[AW+1:2];
  assign unused_addr_bits = ^addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = addr[0];
      default:        misaligned = |addr[1:0];
    endcase
  end

  // Only a fresh request in IDLE can be rejected; an accepted access is
  // already aligned and its inputs are held stable.
  assign fault_now = req & misaligned & (state == IDLE) & ~rst;
`else
  assign fault_now = 1'b0;
`endif

  assign misaligned_fault = fault_now;

  // Byte lane after forcing natural alignment; with the trap enabled a
  // misaligned request never reaches the array, so masking is harmless.
  always_comb begin
    lane = addr[1:0];
    case (funct3)
      3'b000, 3'b100: lane = addr[1:0];
      3'b001, 3'b101: lane = {addr[1], 1'b0};
      default:        lane = 2'b00;
    endcase
  end

  assign word = mem[word_idx];

  // Load lane select and extension.
  always_comb begin
    load_byte  = word[7:0];
    load_half  = lane[1] ? word[31:16] : word[15:0];
    load_value = word;
    case (lane)
      2'd0:    load_byte = word[7:0];
      2'd1:    load_byte = word[15:8];
      2'd2:    load_byte = word[23:16];
      default: load_byte = word[31:24];
    endcase
    case (funct3)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_value = {24'h0, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b101:  load_value = {16'h0, load_half};
      default: load_value = word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick
  // which lanes change.
  always_comb begin
    byte_en    = 4'b1111;
    store_data = write_data;
    case (funct3)
      3'b000, 3'b100: begin
        byte_en    = 4'b0001 << lane;
        store_data = {4{write_data[7:0]}};
      end
      3'b001, 3'b101: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{write_data[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_data = write_data;
      end
    endcase
  end

  // Next-state, counter and busy. Busy is asserted combinationally in the
  // request cycle so the stall lands immediately; reset overrides everything.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    memory_busy = 1'b0;
    enter_done  = 1'b0;
    case (state)
      IDLE: begin
        if (req && !fault_now) begin
          memory_busy = 1'b1;
          if (LATENCY == 1) begin
            state_next = DONE;
            enter_done = 1'b1;
            cnt_next   = '0;
          end else begin
            state_next = ACCESS;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      ACCESS: begin
        memory_busy = 1'b1;
        if (cnt <= CW'(1)) begin
          state_next = DONE;
          enter_done = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rst) begin
      memory_busy = 1'b0;
      enter_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (enter_done && mem_read && !mem_write) begin
        read_data <= load_value;
      end
    end
  end

  // The array has no reset; enter_done is already suppressed during reset,
  // so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (enter_done && mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Scoreboard bench for dmem_responder. Instance dut_a runs LATENCY=2 and
//   instance dut_b runs LATENCY=1. Load expectations are queued when a request
//   is driven and popped when the access reaches DONE. Works with or without
//   DMEM_MISALIGN_TRAP_EN defined.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [2:0]  a_f3, b_f3;
  logic [31:0] a_addr, a_wd, b_addr, b_wd;
  logic [31:0] a_rdata, b_rdata;
  logic        a_busy, b_busy, a_fault, b_fault;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd[2];
  logic [31:0] ref_mem[8];
  logic [2:0]  f3tab[6];

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut_a (
    .clk(clk), .rst(rst), .mem_read(a_rd), .mem_write(a_wr), .funct3(a_f3),
    .addr(a_addr), .write_data(a_wd), .read_data(a_rdata),
    .memory_busy(a_busy), .misaligned_fault(a_fault));

  dmem_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) dut_b (
    .clk(clk), .rst(rst), .mem_read(b_rd), .mem_write(b_wr), .funct3(b_f3),
    .addr(b_addr), .write_data(b_wd), .read_data(b_rdata),
    .memory_busy(b_busy), .misaligned_fault(b_fault));

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic setInputs(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    if (sel) begin
      b_rd = rd; b_wr = wr; b_f3 = f3; b_addr = a; b_wd = wd;
    end else begin
      a_rd = rd; a_wr = wr; a_f3 = f3; a_addr = a; a_wd = wd;
    end
  endtask

  function automatic logic busyOf(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  function automatic logic faultOf(input bit sel);
    return sel ? b_fault : a_fault;
  endfunction

  function automatic logic [31:0] rdataOf(input bit sel);
    return sel ? b_rdata : a_rdata;
  endfunction

  // Reference load: shift the addressed lane down, then extend.
  function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [1:0] ln,
                                            input logic [2:0] f3);
    logic [31:0] sb, sh;
    sb = w >> (8 * ln);
    sh = w >> (16 * ln[1]);
    case (f3)
      3'b000:  return {{24{sb[7]}}, sb[7:0]};
      3'b100:  return {24'h0, sb[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Reference store: merge under a lane mask.
  function automatic logic [31:0] modelStore(input logic [31:0] w, input logic [1:0] ln,
                                             input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] m, d;
    case (f3)
      3'b000, 3'b100: begin m = 32'hFF << (8 * ln);        d = (wd & 32'hFF) << (8 * ln); end
      3'b001, 3'b101: begin m = 32'hFFFF << (16 * ln[1]); d = (wd & 32'hFFFF) << (16 * ln[1]); end
      default:        begin m = 32'hFFFF_FFFF;           d = wd; end
    endcase
    return (w & ~m) | (d & m);
  endfunction

  // Drives one access starting 1 time unit after a rising edge, measures the
  // busy window, checks the DONE-cycle result and returns in the next IDLE
  // cycle at the same phase.
  task automatic applyStimulus(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
    int          n;
    int          lat;
    logic [31:0] e;
    lat = sel ? 1 : 2;
    if (rd && !wr) exp_q.push_back(exp);
    setInputs(sel, rd, wr, f3, a, wd);
    #1;
    checkOutput("fault_clear", 32'(faultOf(sel)), 32'd0);
    n = 0;
    while (busyOf(sel) && n < 20) begin
      n++;
      @(posedge clk);
      #2;
    end
    checkOutput("busy_cycles", 32'(n), 32'(lat));
    if (rd && !wr) begin
      e = exp_q.pop_front();
      checkOutput("load_data", rdataOf(sel), e);
      last_rd[sel] = e;
    end else begin
      checkOutput("rdata_hold", rdataOf(sel), last_rd[sel]);
    end
    setInputs(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d, a;
    logic [2:0]  f3;
    logic [1:0]  ln;
    int          w;
    bit          st;

    f3tab[0] = 3'b000; f3tab[1] = 3'b001; f3tab[2] = 3'b010;
    f3tab[3] = 3'b100; f3tab[4] = 3'b101; f3tab[5] = 3'b011;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;

    // Reset with requests asserted: busy must stay low.
    rst = 1'b1;
    setInputs(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    setInputs(1, 1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput("busy_in_reset_a", 32'(a_busy), 32'd0);
    checkOutput("busy_in_reset_b", 32'(b_busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("rdata_reset", a_rdata, 32'h0);
    checkOutput("fault_reset", 32'(a_fault), 32'd0);
    setInputs(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    setInputs(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] word store and lane loads");
    applyStimulus(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF);
    applyStimulus(0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE);
    applyStimulus(0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE);
    applyStimulus(0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD);
    applyStimulus(0, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF);

    $display("[TB] byte store");
    applyStimulus(0, 1'b0, 1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF);
    applyStimulus(0, 1'b1, 1'b0, 3'b100, 32'h10, 32'h0, 32'h000000EF);

    $display("[TB] misaligned word load");
`ifdef DMEM_MISALIGN_TRAP_EN
    setInputs(0, 1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
    #1;
    checkOutput("misalign_fault", 32'(a_fault), 32'd1);
    checkOutput("misalign_busy", 32'(a_busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("misalign_busy_next", 32'(a_busy), 32'd0);
    checkOutput("misalign_rdata", a_rdata, last_rd[0]);
    setInputs(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF);
`else
    applyStimulus(0, 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'hDEAD55EF);
`endif

    $display("[TB] read+write together and undefined funct3");
    applyStimulus(0, 1'b1, 1'b1, 3'b010, 32'h14, 32'hCAFEF00D, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 3'b011, 32'h14, 32'h0, 32'hCAFEF00D);
    applyStimulus(0, 1'b1, 1'b0, 3'b111, 32'h14, 32'h0, 32'hCAFEF00D);

    $display("[TB] reset during access");
    applyStimulus(0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h11111111, 32'h0);
    setInputs(0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h22222222);
    #1;
    checkOutput("abort_busy_start", 32'(a_busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy_in_rst", 32'(a_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    setInputs(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("abort_busy_after", 32'(a_busy), 32'd0);
    checkOutput("abort_rdata_zero", a_rdata, 32'h0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h11111111);

    $display("[TB] latency 1 with address wrap");
    applyStimulus(1, 1'b0, 1'b1, 3'b010, 32'h1000, 32'hA5A5A5A5, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'hA5A5A5A5);

    $display("[TB] random accesses against model");
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      ref_mem[i] = d;
      applyStimulus(0, 1'b0, 1'b1, 3'b010, 32'h40 + 32'(4 * i), d, 32'h0);
    end
    for (int k = 0; k < 24; k++) begin
      w  = $urandom_range(0, 7);
      f3 = f3tab[$urandom_range(0, 5)];
      case (f3)
        3'b000, 3'b100: ln = 2'($urandom_range(0, 3));
        3'b001, 3'b101: ln = {1'($urandom_range(0, 1)), 1'b0};
        default:        ln = 2'b00;
      endcase
      a  = 32'h40 + 32'(4 * w) + 32'(ln);
      d  = $urandom;
      st = ($urandom_range(0, 1) == 1);
      if (st) begin
        ref_mem[w] = modelStore(ref_mem[w], ln, f3, d);
        applyStimulus(0, 1'b0, 1'b1, f3, a, d, 32'h0);
      end else begin
        applyStimulus(0, 1'b1, 1'b0, f3, a, 32'h0, modelLoad(ref_mem[w], ln, f3));
      end
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 3'b010, 32'h40 + 32'(4 * i), 32'h0, ref_mem[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the MEM stage of the RV32I pipeline; it is the producer of the `memory_busy` stall request. It accepts the load/store presented by the MEM stage and holds `memory_busy` high for a fixed access latency so the stall controller freezes PC and IF/ID. It then returns sign/zero-extended load data, or commits byte-enabled store data, and releases the pipeline.

## Interface
- `LATENCY`, 2: number of consecutive cycles `memory_busy` is held per access; legal range ≥1.
- `DEPTH_WORDS`, 1024: word count of the internal array; must be a power of 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: load request from MEM stage; held stable while `memory_busy`=1.
- `mem_write` in 1: store request from MEM stage; held stable while `memory_busy`=1.
- `funct3` in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` in 32: byte address.
- `write_data` in 32: store data, LSB-aligned.
- `read_data` out 32: extended load data; registered.
- `memory_busy` out 1: stall request to the stall controller.
- `misaligned_fault` out 1: misaligned-access flag to the trap logic.

## Operation
- States: IDLE, ACCESS, DONE. Latency counter width is clog2(LATENCY+1).
- IDLE with no request: `memory_busy`=0; state remains IDLE.
- IDLE with a request: `memory_busy`=1 combinationally in the same cycle, so the stall takes effect immediately. Next state is ACCESS, or DONE when LATENCY=1.
- ACCESS: `memory_busy`=1; the counter decrements. The transition to DONE occurs so that busy is high for exactly LATENCY cycles in total.
- Edge entering DONE:
  - Load: the word is read, the lane is selected (byte `addr[1:0]`, half `addr[1]`), and the result is sign- or zero-extended per funct3 into `read_data`.
  - Store: the array is written with byte enables: SB sets 1 lane, SH sets 2, SW sets 4.
- DONE: `memory_busy`=0 and the pipeline advances on this edge. Next state is always IDLE, even if the request inputs are still asserted.
- Word index is `addr[clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap.
- `mem_read` and `mem_write` both high: treated as a store; `read_data` is unchanged.
- Undefined funct3 (011, 110, 111): treated as W.
- `read_data` holds its last value except on a load's DONE entry.

## Timing
- Reset values: state IDLE, counter 0, `read_data`=0, `memory_busy`=0, `misaligned_fault`=0. The array is not cleared.
- While `rst`=1, `memory_busy` is forced to 0 regardless of requests.
- Reset mid-access aborts the access: no array write, and `read_data` is reset to 0.
- Request at cycle 0 gives `memory_busy`=1 during cycles 0..LATENCY-1 and DONE at cycle LATENCY. Load data is visible in cycle LATENCY.
- Back-to-back accesses: a new request can start no earlier than the cycle after DONE, so the minimum period is LATENCY+1 cycles.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - H/HU with `addr[0]`≠0, or W with `addr[1:0]`≠0, raises `misaligned_fault`=1 combinationally in IDLE.
  - For such a request `memory_busy`=0, state stays IDLE, no write occurs, and `read_data` is unchanged.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - `misaligned_fault` is tied to 0.
  - Address low bits below the access size are forced to 0 (naturally aligned) and the access proceeds normally.

## Test plan
- LATENCY=2, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> busy high exactly 2 cycles per access, 1 DONE cycle between accesses; `read_data`=0xDEADBEEF.
- After that store, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF; other lanes unchanged.
- `DMEM_MISALIGN_TRAP_EN` defined, LW 0x12 -> `misaligned_fault`=1, busy 0, array and `read_data` unchanged. Macro undefined, LW 0x12 -> fault 0, returns word at 0x10.
- `rst` asserted during ACCESS of an SW to 0x20 (old value 0x11111111) -> busy 0 in the reset cycle and next cycle IDLE; a subsequent LW 0x20 returns 0x11111111.
- LATENCY=1 and DEPTH_WORDS=1024: SW 0x1000 data 0xA5A5A5A5 then LW 0x0 -> busy 1 cycle, wraps to index 0, `read_data`=0xA5A5A5A5.
